uart_rx_frame: RTL

UART receiver that deserializes the 8N1 serial pixel stream on `bit_in` and writes each byte into the LeNet-5 input image buffer. It counts bytes against a fixed frame size, pulses `frame_done` when a full 42×42 image has landed, and then rearms for the next image. It sits between the board RX pin and the image RAM write port at the front of `top`, and is the receive end of the `uart_tx_test` serial link.

---
 rtl/lenet_uart_pkg.sv | 28 ++
 rtl/uart_rx_byte.sv | 162 ++++++++++++++++
 rtl/uart_rx_frame.sv | 126 ++++++++++++
 3 files changed

// File: rtl/lenet_uart_pkg.sv
// Shared definitions for the LeNet-5 serial image link (receiver and test transmitter).
package lenet_uart_pkg;

  // Board clock and line rate shared by both ends of the link.
  localparam int CLK_FREQ_DEFAULT    = 50_000_000;
  localparam int BAUD_DEFAULT        = 115_200;

  // One 42x42 greyscale image, one byte per pixel.
  localparam int FRAME_BYTES_DEFAULT = 1764;

  // Byte receiver states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // Number of address bits needed to index n bytes.
  function automatic int addr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Image buffer address width for the default frame size.
  localparam int FRAME_ADDR_W = addr_width(FRAME_BYTES_DEFAULT);

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchronizer, byte FSM and bit timer.
// Samples each bit at its centre; returns to IDLE at mid-stop so that a
// start bit directly following the stop bit is never missed.
module uart_rx_byte
  import lenet_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLK_FREQ_DEFAULT / BAUD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_err,
  output logic       rx_idle
);

  localparam int             TW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0]  HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0]  BIT_LAST  = TW'(CLKS_PER_BIT - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          rx_s;

  rx_state_e     state_r;
  rx_state_e     state_next_s;
  logic [TW-1:0] timer_r;
  logic [TW-1:0] timer_next_s;
  logic [2:0]    idx_r;
  logic [2:0]    idx_next_s;
  logic [7:0]    shift_r;
  logic [7:0]    shift_next_s;
  logic [7:0]    data_r;
  logic [7:0]    data_next_s;
  logic          valid_r;
  logic          valid_next_s;
  logic          err_r;
  logic          err_next_s;

  assign rx_s       = sync2_r;
  assign byte_valid = valid_r;
  assign byte_data  = data_r;
  assign stop_err   = err_r;
  assign rx_idle    = (state_r == ST_IDLE);

  // Two-flop synchronizer for the asynchronous line; resets to the idle (high) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= bit_in;
      sync2_r <= sync1_r;
    end
  end

  // State, timer and shift register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      timer_r <= '0;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      timer_r <= timer_next_s;
      idx_r   <= idx_next_s;
      shift_r <= shift_next_s;
      data_r  <= data_next_s;
      valid_r <= valid_next_s;
      err_r   <= err_next_s;
    end
  end

  // Next-state and datapath decode for the byte FSM.
  always_comb begin
    state_next_s = state_r;
    timer_next_s = timer_r;
    idx_next_s   = idx_r;
    shift_next_s = shift_r;
    data_next_s  = data_r;
    valid_next_s = 1'b0;
    err_next_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        timer_next_s = '0;
        if (!rx_s) begin
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_START: begin
        if (timer_r == HALF_LAST) begin
          timer_next_s = '0;
          idx_next_s   = 3'd0;
          if (rx_s) begin
            // Line went back high before mid-start: treat as a glitch.
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_DATA;
          end
        end else begin
          timer_next_s = timer_r + TW'(1);
        end
      end

      ST_DATA: begin
        if (timer_r == BIT_LAST) begin
          timer_next_s        = '0;
          shift_next_s[idx_r] = rx_s;
          if (idx_r == 3'd7) begin
            idx_next_s   = 3'd0;
            state_next_s = ST_STOP;
          end else begin
            idx_next_s   = idx_r + 3'd1;
          end
        end else begin
          timer_next_s = timer_r + TW'(1);
        end
      end

      ST_STOP: begin
        if (timer_r == BIT_LAST) begin
          timer_next_s = '0;
          if (rx_s) begin
            valid_next_s = 1'b1;
            data_next_s  = shift_r;
            state_next_s = ST_IDLE;
          end else begin
            // Framing error: byte is dropped, wait for the line to recover.
            err_next_s   = 1'b1;
            state_next_s = ST_BREAK;
          end
        end else begin
          timer_next_s = timer_r + TW'(1);
        end
      end

      ST_BREAK: begin
        timer_next_s = '0;
        if (rx_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_BREAK;
        end
      end

      default: begin
        timer_next_s = '0;
        state_next_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/uart_rx_frame.sv
// Image-frame receiver: places each received byte at the next address of the
// image buffer, flags the end of a full frame, and discards a partial frame
// after a long mid-frame silence.
module uart_rx_frame
  import lenet_uart_pkg::*;
#(
  parameter int CLK_FREQ     = CLK_FREQ_DEFAULT,
  parameter int BAUD         = BAUD_DEFAULT,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int FRAME_BYTES  = FRAME_BYTES_DEFAULT,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bit_in,
  output logic                    wr_en,
  output logic [FRAME_ADDR_W-1:0] wr_addr,
  output logic [7:0]              wr_data,
  output logic                    frame_done,
  output logic                    frame_abort,
  output logic                    frame_err,
  output logic                    busy
);

  localparam logic [FRAME_ADDR_W-1:0] FRAME_LAST = FRAME_ADDR_W'(FRAME_BYTES - 1);
  localparam int                      TO_CLKS    = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int                      TOW        = $clog2(TO_CLKS + 1);
  localparam logic [TOW-1:0]          TO_LAST    = TOW'(TO_CLKS - 1);

  logic                    byte_valid_s;
  logic [7:0]              byte_data_s;
  logic                    stop_err_s;
  logic                    rx_idle_s;

  logic [FRAME_ADDR_W-1:0] wr_ptr_r;
  logic [FRAME_ADDR_W-1:0] wr_ptr_next_s;
  logic [TOW-1:0]          to_cnt_r;
  logic [TOW-1:0]          to_cnt_next_s;
  logic                    done_next_s;
  logic                    abort_next_s;

  logic                    wr_en_r;
  logic [FRAME_ADDR_W-1:0] wr_addr_r;
  logic [7:0]              wr_data_r;
  logic                    frame_done_r;
  logic                    frame_abort_r;
  logic                    frame_err_r;
  logic                    busy_r;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .byte_valid (byte_valid_s),
    .byte_data  (byte_data_s),
    .stop_err   (stop_err_s),
    .rx_idle    (rx_idle_s)
  );

  assign wr_en       = wr_en_r;
  assign wr_addr     = wr_addr_r;
  assign wr_data     = wr_data_r;
  assign frame_done  = frame_done_r;
  assign frame_abort = frame_abort_r;
  assign frame_err   = frame_err_r;
  assign busy        = busy_r;

  // Frame pointer advance/wrap and the mid-frame idle timeout.
  always_comb begin
    wr_ptr_next_s = wr_ptr_r;
    to_cnt_next_s = to_cnt_r;
    done_next_s   = 1'b0;
    abort_next_s  = 1'b0;

    if (byte_valid_s) begin
      to_cnt_next_s = '0;
      if (wr_ptr_r == FRAME_LAST) begin
        wr_ptr_next_s = '0;
        done_next_s   = 1'b1;
      end else begin
        wr_ptr_next_s = wr_ptr_r + FRAME_ADDR_W'(1);
      end
    end else if (rx_idle_s && (wr_ptr_r != '0)) begin
      if (to_cnt_r == TO_LAST) begin
        to_cnt_next_s = '0;
        wr_ptr_next_s = '0;
        abort_next_s  = 1'b1;
      end else begin
        to_cnt_next_s = to_cnt_r + TOW'(1);
      end
    end else begin
      // A byte is in flight or no frame is open: keep the timeout cleared.
      to_cnt_next_s = '0;
    end
  end

  // Frame state and registered write-port / status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r      <= '0;
      to_cnt_r      <= '0;
      wr_en_r       <= 1'b0;
      wr_addr_r     <= '0;
      wr_data_r     <= 8'h00;
      frame_done_r  <= 1'b0;
      frame_abort_r <= 1'b0;
      frame_err_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      wr_ptr_r      <= wr_ptr_next_s;
      to_cnt_r      <= to_cnt_next_s;
      wr_en_r       <= byte_valid_s;
      frame_done_r  <= done_next_s;
      frame_abort_r <= abort_next_s;
      frame_err_r   <= stop_err_s;
      busy_r        <= (wr_ptr_next_s != '0);
      if (byte_valid_s) begin
        wr_addr_r <= wr_ptr_r;
        wr_data_r <= byte_data_s;
      end
    end
  end

endmodule
